// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch/decode widths, constants and the IF/ID record
package if_stage_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'd0;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
    logic valid;
  } if_id_t;
endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: pipeline register where flush beats freeze and freeze beats load
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   freeze,
  input  if_id_t d,
  output if_id_t q
);
  localparam if_id_t BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= BUBBLE;
    else if (flush) q <= BUBBLE;
    else if (!freeze) q <= d;
endmodule

// File: rtl/if_stage.sv
// if_stage: program counter, next-PC selection and IF/ID capture of fetched words
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'd0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic               flush,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_valid,
  output logic [15:0]        fetch_count
);
  logic [ADDR_W-1:0] pc_q, pc_inc, pc_d;
  logic squash, load;
  if_id_t id_q;
  always_comb begin
    pc_inc = pc_q + PC_STEP;
    pc_d = branch_taken ? (branch_addr & ~32'd3) : freeze ? pc_q : pc_inc;
    squash = branch_taken | flush;
    load = !squash && !freeze;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fetch_count <= '0;
    else if (load && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk(clk),
    .rst_n(rst_n),
    .flush(squash),
    .freeze(freeze),
    .d('{pc: pc_inc, instr: imem_data, valid: 1'b1}),
    .q(id_q)
  );
  assign imem_addr = pc_q;
  assign id_pc = id_q.pc;
  assign id_instr = id_q.instr;
  assign id_valid = id_q.valid;
endmodule
